bsg_chip_io_ct_rx_demux: RTL and testbench
==========================================

// Module: bsg_chip_io_ct_rx_demux
// PURPOSE
// Receive half of the core-side channel tunnel for a chip IO link. Accepts the
// multiplexed stream leaving bsg_link_ddr_downstream, steers each word into a
// per-channel buffer by tag, and presents each channel as a valid/yumi source to
// the router-side hop fifos. Consumed entries are counted per channel and
// returned as decimated credit bundles to the local transmit half. Incoming
// remote credit words are forwarded to the transmit half.
// PARAMETERS
// width_p                 32   payload width per channel word
// num_in_p                2    number of tunnelled channels (>=1)
// remote_credits_p        64   buffer depth per channel, = sender's credit allowance
// lg_credit_decimation_p  4    return credits once a counter reaches 2**this
// tag_width_lp            $clog2(num_in_p+1)  (local) tag field width
// cnt_width_lp            $clog2(remote_credits_p+1)  (local) credit count width
// PORTS
// clk_i           in   1                          core clock
// reset_i         in   1                          sync active-high reset
// multi_v_i       in   1                          muxed word valid
// multi_data_i    in   tag_width_lp+width_p       {tag, payload}
// multi_yumi_o    out  1                          muxed word consumed
// v_o             out  num_in_p                   channel word valid
// data_o          out  num_in_p*width_p           channel payload
// yumi_i          in   num_in_p                   channel word consumed
// credit_v_o      out  1                          local credit bundle ready
// credit_data_o   out  num_in_p*cnt_width_lp      per-channel freed-entry counts
// credit_yumi_i   in   1                          bundle taken by transmit half
// rcredit_v_o     out  1                          remote credit word pulse
// rcredit_data_o  out  num_in_p*cnt_width_lp      remote credit counts
// overflow_o      out  1                          sticky: word dropped, buffer full
// BEHAVIOUR
// - One clock; reset is synchronous and active-high. Reset: all buffers empty,
//   counters 0; v_o, credit_v_o, rcredit_v_o, overflow_o, multi_yumi_o all 0.
// - multi_yumi_o = multi_v_i & ~reset_i (always accepted; credits guarantee room).
// - tag < num_in_p: payload enqueued into buffer[tag]; visible on v_o[tag] the
//   next cycle (registered, no same-cycle bypass). Buffer full on arrival: word
//   dropped, overflow_o set and held until reset; other channels unaffected.
// - tag == num_in_p: credit word; rcredit_data_o <= low num_in_p*cnt_width_lp
//   payload bits, rcredit_v_o pulses 1 cycle later for exactly 1 cycle.
// - tag > num_in_p: word consumed and discarded, overflow_o set.
// - Buffers: FIFO, depth remote_credits_p each; v_o[i] = ~empty[i]; yumi_i[i]
//   only when v_o[i] (violation asserts in sim). Enqueue and dequeue same cycle
//   on a full buffer is legal: dequeue frees the slot first, no overflow.
// - Credit counter cnt[i] increments on yumi_i[i]. credit_v_o is registered-
//   from-state: 1 when any cnt[i] >= 2**lg_credit_decimation_p; credit_data_o
//   = cnt (combinational from counters). On credit_yumi_i & credit_v_o:
//   cnt[i] <= yumi_i[i] (same-cycle yumi not lost). credit_v_o may stay high.
// - cnt[i] never exceeds remote_credits_p (bounded by buffer occupancy).
// - Elaboration error if remote_credits_p < 2**lg_credit_decimation_p or
//   num_in_p*cnt_width_lp > width_p.
// - reset_i mid-operation: buffered words and unreturned counts discarded in
//   one cycle; link resets are sequenced so the sender resets alongside.
// TESTING
// - Reset, then idle 10 cycles -> all outputs 0, multi_yumi_o 0 while v low.
// - Tag 0 payload 0xA5A5_0001, then tag 1 0x0000_0002 -> v_o[0] next cycle
//   data 0xA5A5_0001; v_o[1] the cycle after, data 0x2; order kept per channel.
// - 16 words on ch0, yumi all, credit_yumi_i low -> credit_v_o rises the cycle
//   after 16th yumi, credit_data_o ch0=16 ch1=0; yumi with concurrent ch0
//   yumi -> ch0 count becomes 1, credit_v_o drops.
// - 65 words to ch1 with no yumi -> 64 buffered, overflow_o=1 after 65th;
//   a 65th word concurrent with one yumi -> no overflow.
// - Tag 2 word payload {cnt1=5, cnt0=3} -> rcredit_v_o 1-cycle pulse with
//   those counts; no channel v_o change.
// - Random tags/yumi, 10k words, reset asserted at word 5000 -> scoreboard
//   match, buffers empty and counts 0 the cycle after reset.

Source files
------------

// File: rtl/bsg_chip_io_ct_rx_demux.sv
// bsg_chip_io_ct_rx_demux: steers tagged link words into per-channel fifos and returns decimated credits
module bsg_chip_io_ct_rx_demux #(
  parameter int width_p = 32,
  parameter int num_in_p = 2,
  parameter int remote_credits_p = 64,
  parameter int lg_credit_decimation_p = 4,
  localparam int tag_width_lp = $clog2(num_in_p + 1),
  localparam int cnt_width_lp = $clog2(remote_credits_p + 1)
) (
  input  logic                             clk_i,
  input  logic                             reset_i,
  input  logic                             multi_v_i,
  input  logic [tag_width_lp+width_p-1:0]  multi_data_i,
  output logic                             multi_yumi_o,
  output logic [num_in_p-1:0]              v_o,
  output logic [num_in_p*width_p-1:0]      data_o,
  input  logic [num_in_p-1:0]              yumi_i,
  output logic                             credit_v_o,
  output logic [num_in_p*cnt_width_lp-1:0] credit_data_o,
  input  logic                             credit_yumi_i,
  output logic                             rcredit_v_o,
  output logic [num_in_p*cnt_width_lp-1:0] rcredit_data_o,
  output logic                             overflow_o
);
  localparam int ptr_w = remote_credits_p > 1 ? $clog2(remote_credits_p) : 1;
  localparam logic [tag_width_lp-1:0] credit_tag = tag_width_lp'(num_in_p);
  localparam logic [cnt_width_lp-1:0] depth = cnt_width_lp'(remote_credits_p);
  localparam logic [cnt_width_lp-1:0] thresh = cnt_width_lp'(2 ** lg_credit_decimation_p);
  localparam logic [ptr_w-1:0] last = ptr_w'(remote_credits_p - 1);

  if (remote_credits_p < 2 ** lg_credit_decimation_p || num_in_p * cnt_width_lp > width_p) begin : g_bad_params
    $error("bsg_chip_io_ct_rx_demux: illegal parameter combination");
  end

  logic [tag_width_lp-1:0] tag;
  logic [width_p-1:0] payload;
  logic [width_p-1:0] mem [num_in_p][remote_credits_p];
  logic [ptr_w-1:0] rd_q [num_in_p], rd_d [num_in_p], wr_q [num_in_p], wr_d [num_in_p];
  logic [cnt_width_lp-1:0] occ_q [num_in_p], occ_d [num_in_p], cnt_q [num_in_p], cnt_d [num_in_p];
  logic [num_in_p-1:0] enq, deq;
  logic overflow_q, overflow_d, credit_v_q, credit_v_d, rcredit_v_q, rcredit_v_d;
  logic [num_in_p*cnt_width_lp-1:0] rcredit_data_q, rcredit_data_d;

  assign tag = multi_data_i[width_p +: tag_width_lp];
  assign payload = multi_data_i[width_p-1:0];
  assign multi_yumi_o = multi_v_i & ~reset_i;
  assign credit_v_o = credit_v_q;
  assign rcredit_v_o = rcredit_v_q;
  assign rcredit_data_o = rcredit_data_q;
  assign overflow_o = overflow_q;

  // next-state for fifo pointers, occupancy, credit counters and the credit/overflow flags
  always_comb begin
    v_o = '0;
    data_o = '0;
    credit_data_o = '0;
    credit_v_d = 1'b0;
    overflow_d = overflow_q | (multi_yumi_o & (tag > credit_tag));
    for (int i = 0; i < num_in_p; i++) begin
      v_o[i] = occ_q[i] != '0;
      data_o[i*width_p +: width_p] = mem[i][rd_q[i]];
      credit_data_o[i*cnt_width_lp +: cnt_width_lp] = cnt_q[i];
      deq[i] = yumi_i[i] & v_o[i];
      enq[i] = multi_yumi_o & (tag == tag_width_lp'(i)) & ((occ_q[i] != depth) | deq[i]);
      overflow_d = overflow_d | (multi_yumi_o & (tag == tag_width_lp'(i)) & ~enq[i]);
      rd_d[i] = deq[i] ? ((rd_q[i] == last) ? '0 : rd_q[i] + ptr_w'(1)) : rd_q[i];
      wr_d[i] = enq[i] ? ((wr_q[i] == last) ? '0 : wr_q[i] + ptr_w'(1)) : wr_q[i];
      occ_d[i] = occ_q[i] + cnt_width_lp'(enq[i]) - cnt_width_lp'(deq[i]);
      cnt_d[i] = (credit_yumi_i & credit_v_q) ? cnt_width_lp'(deq[i]) : cnt_q[i] + cnt_width_lp'(deq[i]);
      credit_v_d = credit_v_d | (cnt_d[i] >= thresh);
    end
    rcredit_v_d = multi_yumi_o & (tag == credit_tag);
    rcredit_data_d = rcredit_v_d ? payload[num_in_p*cnt_width_lp-1:0] : rcredit_data_q;
  end

  // state registers; reset discards buffered words and unreturned counts in one cycle
  always_ff @(posedge clk_i) begin
    for (int i = 0; i < num_in_p; i++) begin
      rd_q[i] <= reset_i ? '0 : rd_d[i];
      wr_q[i] <= reset_i ? '0 : wr_d[i];
      occ_q[i] <= reset_i ? '0 : occ_d[i];
      cnt_q[i] <= reset_i ? '0 : cnt_d[i];
    end
    overflow_q <= reset_i ? 1'b0 : overflow_d;
    credit_v_q <= reset_i ? 1'b0 : credit_v_d;
    rcredit_v_q <= reset_i ? 1'b0 : rcredit_v_d;
    rcredit_data_q <= reset_i ? '0 : rcredit_data_d;
  end

  // payload storage; contents need no reset since occupancy gates visibility
  always_ff @(posedge clk_i) begin
    for (int i = 0; i < num_in_p; i++) begin
      if (enq[i]) mem[i][wr_q[i]] <= payload;
    end
  end

  a_yumi_needs_valid: assert property (@(posedge clk_i) disable iff (reset_i) (yumi_i & ~v_o) == '0);
endmodule

// File: tb/tb_bsg_chip_io_ct_rx_demux.sv
// tb_bsg_chip_io_ct_rx_demux: directed and random checks against a queue-based reference model
module tb_bsg_chip_io_ct_rx_demux;
  localparam int W = 32, N = 2, D = 64, CW = 7, TH = 16;
  logic clk_i = 0, reset_i = 1, multi_v_i = 0, credit_yumi_i = 0;
  logic [W+1:0] multi_data_i = '0;
  logic multi_yumi_o, credit_v_o, rcredit_v_o, overflow_o;
  logic [N-1:0] v_o, yumi_i = '0;
  logic [N*W-1:0] data_o;
  logic [N*CW-1:0] credit_data_o, rcredit_data_o;
  int n_assert = 0, n_fail = 0;
  logic [W-1:0] q [N][$];
  int cnt [N];
  bit ov, rcv;
  logic [N*CW-1:0] rcd;

  always #5 clk_i = ~clk_i;

  bsg_chip_io_ct_rx_demux #(.width_p(W), .num_in_p(N), .remote_credits_p(D), .lg_credit_decimation_p(4)) dut (
    .clk_i(clk_i), .reset_i(reset_i), .multi_v_i(multi_v_i), .multi_data_i(multi_data_i),
    .multi_yumi_o(multi_yumi_o), .v_o(v_o), .data_o(data_o), .yumi_i(yumi_i),
    .credit_v_o(credit_v_o), .credit_data_o(credit_data_o), .credit_yumi_i(credit_yumi_i),
    .rcredit_v_o(rcredit_v_o), .rcredit_data_o(rcredit_data_o), .overflow_o(overflow_o)
  );

  task automatic chk(input string name, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", name, obs, exp);
    end
  endtask

  function automatic bit credit_due();
    bit r = 0;
    for (int i = 0; i < N; i++) r |= cnt[i] >= TH;
    return r;
  endfunction

  task automatic check_all();
    for (int i = 0; i < N; i++) begin
      chk($sformatf("v%0d", i), v_o[i], q[i].size() != 0);
      if (q[i].size() != 0) chk($sformatf("data%0d", i), data_o[i*W +: W], q[i][0]);
      chk($sformatf("cnt%0d", i), credit_data_o[i*CW +: CW], cnt[i]);
    end
    chk("credit_v", credit_v_o, credit_due());
    chk("rcredit_v", rcredit_v_o, rcv);
    chk("rcredit_data", rcredit_data_o, rcd);
    chk("overflow", overflow_o, ov);
  endtask

  task automatic do_reset();
    reset_i = 1; multi_v_i = 1; multi_data_i = {2'd0, $urandom()}; yumi_i = '0; credit_yumi_i = 1;
    #1 chk("reset_multi_yumi", multi_yumi_o, 0);
    @(posedge clk_i); #1;
    reset_i = 0; multi_v_i = 0; credit_yumi_i = 0;
    for (int i = 0; i < N; i++) begin q[i].delete(); cnt[i] = 0; end
    ov = 0; rcv = 0; rcd = '0;
    check_all();
  endtask

  task automatic cyc(input bit mv, input logic [1:0] tg, input logic [W-1:0] pay, input logic [N-1:0] y, input bit cy);
    logic [N-1:0] ym;
    bit take;
    for (int i = 0; i < N; i++) ym[i] = y[i] && q[i].size() != 0;
    multi_v_i = mv; multi_data_i = {tg, pay}; yumi_i = ym; credit_yumi_i = cy;
    #1 chk("multi_yumi", multi_yumi_o, mv);
    take = cy && credit_due();
    for (int i = 0; i < N; i++) begin
      if (ym[i]) void'(q[i].pop_front());
      cnt[i] = take ? int'(ym[i]) : cnt[i] + int'(ym[i]);
    end
    rcv = 0;
    if (mv) begin
      if (tg < N) begin
        if (q[tg].size() < D) q[tg].push_back(pay); else ov = 1;
      end else if (tg == N) begin
        rcv = 1; rcd = pay[N*CW-1:0];
      end else ov = 1;
    end
    @(posedge clk_i); #1;
    multi_v_i = 0; yumi_i = '0; credit_yumi_i = 0;
    check_all();
  endtask

  initial begin
    int words;
    bit mv;
    int r;
    logic [1:0] tg;
    do_reset();
    repeat (10) cyc(0, 0, 0, 0, 0);
    chk("idle_v", v_o, 0);
    chk("idle_credit_v", credit_v_o, 0);
    chk("idle_overflow", overflow_o, 0);
    cyc(1, 0, 32'hA5A5_0001, 0, 0);
    chk("t2_v0", v_o[0], 1);
    chk("t2_d0", data_o[31:0], 32'hA5A5_0001);
    chk("t2_v1_still_low", v_o[1], 0);
    cyc(1, 1, 32'h2, 0, 0);
    chk("t2_v1", v_o[1], 1);
    chk("t2_d1", data_o[63:32], 32'h2);
    cyc(1, 0, 32'h1234, 2'b11, 0);
    chk("t2_order", data_o[31:0], 32'h1234);
    cyc(0, 0, 0, 2'b01, 0);
    do_reset();
    for (int i = 0; i < 16; i++) cyc(1, 0, 32'(i), 0, 0);
    repeat (15) cyc(0, 0, 0, 2'b01, 0);
    chk("t3_credit_v_early", credit_v_o, 0);
    cyc(0, 0, 0, 2'b01, 0);
    chk("t3_credit_v", credit_v_o, 1);
    chk("t3_cnt0", credit_data_o[CW-1:0], 16);
    chk("t3_cnt1", credit_data_o[2*CW-1:CW], 0);
    cyc(1, 0, 32'd77, 0, 0);
    chk("t3_credit_v_hold", credit_v_o, 1);
    cyc(0, 0, 0, 2'b01, 1);
    chk("t3_cnt0_after_take", credit_data_o[CW-1:0], 1);
    chk("t3_credit_v_drop", credit_v_o, 0);
    do_reset();
    for (int i = 0; i < 64; i++) cyc(1, 1, 32'(i + 100), 0, 0);
    chk("t4_no_overflow_64", overflow_o, 0);
    cyc(1, 1, 32'd999, 0, 0);
    chk("t4_overflow_65", overflow_o, 1);
    chk("t4_head", data_o[63:32], 100);
    do_reset();
    chk("t4_overflow_cleared", overflow_o, 0);
    for (int i = 0; i < 64; i++) cyc(1, 1, 32'(i), 0, 0);
    cyc(1, 1, 32'd555, 2'b10, 0);
    chk("t4_full_enq_deq", overflow_o, 0);
    repeat (64) cyc(0, 0, 0, 2'b10, 1);
    chk("t4_last_word_seen", v_o[1], 0);
    do_reset();
    cyc(1, 2, (32'd5 << CW) | 32'd3, 0, 0);
    chk("t5_rcredit_v", rcredit_v_o, 1);
    chk("t5_rcredit_data", rcredit_data_o, {7'd5, 7'd3});
    chk("t5_no_channel_v", v_o, 0);
    cyc(0, 0, 0, 0, 0);
    chk("t5_rcredit_pulse_end", rcredit_v_o, 0);
    cyc(1, 3, 32'hDEAD, 0, 0);
    chk("t5_bad_tag_overflow", overflow_o, 1);
    do_reset();
    words = 0;
    while (words < 10000) begin
      if (words == 5000 && multi_v_i == 0 && n_assert > 0 && q[0].size() + q[1].size() >= 0 && !reset_i) begin
        do_reset();
        chk("rand_reset_v", v_o, 0);
        chk("rand_reset_cnt", credit_data_o, 0);
        words++;
      end
      mv = ($urandom() % 4) != 0;
      r = int'($urandom() % 64);
      tg = r < 30 ? 2'd0 : r < 60 ? 2'd1 : r < 63 ? 2'd2 : 2'd3;
      cyc(mv, tg, $urandom(), 2'($urandom()), 1'($urandom()));
      words += int'(mv);
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
